// File: rtl/div_ctrl_if.sv
// div_ctrl_if: decoder/EX-side bundle for the multi-cycle divider.
//
// Handshake: start_i is the request and stays high, with signed_i/a_i/b_i,
// until done_o is seen. done_o is the completion strobe and the HI/LO write
// enable qualifier for hi_o/lo_o. stall_o holds the pipeline while a request
// is pending and not yet complete. flush_i aborts the request at any time and
// suppresses its done_o. hold_i keeps a finished result (done_o high) frozen.
interface div_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             flush_i;
  logic             hold_i;
  logic             stall_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  // Pipeline (requester) side
  modport master (
    output start_i, signed_i, a_i, b_i, flush_i, hold_i,
    input  stall_o, done_o, hi_o, lo_o
  );

  // Divider side
  modport slave (
    input  start_i, signed_i, a_i, b_i, flush_i, hold_i,
    output stall_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle restoring divider controller for the EX stage.
// Runs WIDTH shift-subtract iterations for DIV/DIVU, stalls the pipeline while
// busy, and presents quotient (lo_o) / remainder (hi_o) in the DONE cycle.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor completes IDLE->DONE
// directly with the same result the full iteration would produce.
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       resetn,
  div_ctrl_if.slave  bus,
  output logic [1:0] state_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             qneg_q;
  logic             rneg_q;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;

  // Operand magnitudes; 0x80000000 negates to itself and is used as unsigned.
  assign a_neg = bus.signed_i & bus.a_i[WIDTH-1];
  assign b_neg = bus.signed_i & bus.b_i[WIDTH-1];
  assign a_mag = a_neg ? -bus.a_i : bus.a_i;
  assign b_mag = b_neg ? -bus.b_i : bus.b_i;

  // One restoring iteration plus the sign fix-up of its result.
  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, divisor_q};
    rem_d     = rem_shift[WIDTH-1:0];
    quo_d     = {quo_q[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_d = trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end
    lo_d = qneg_q ? -quo_d : quo_d;
    hi_d = rneg_q ? -rem_d : rem_d;
  end

  // Control FSM with datapath registers; flush wins over start and hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.flush_i && bus.start_i) begin
            quo_q     <= a_mag;
            rem_q     <= '0;
            divisor_q <= b_mag;
            cnt_q     <= '0;
            qneg_q    <= a_neg ^ b_neg;
            rneg_q    <= a_neg;
`ifdef DIV_ZERO_FAST_EN
            if (bus.b_i == '0) begin
              // All-ones quotient magnitude, remainder equals the dividend.
              state_q <= DONE;
              lo_q    <= a_neg ? {{(WIDTH-1){1'b0}}, 1'b1} : '1;
              hi_q    <= bus.a_i;
            end else begin
              state_q <= BUSY;
            end
`else
            state_q <= BUSY;
`endif
          end
        end
        BUSY: begin
          if (bus.flush_i) begin
            state_q <= IDLE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == LAST) begin
              state_q <= DONE;
              hi_q    <= hi_d;
              lo_q    <= lo_d;
            end
          end
        end
        DONE: begin
          if (bus.flush_i || !bus.hold_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.done_o  = (state_q == DONE);
  assign bus.stall_o = resetn & bus.start_i & ~bus.done_o & ~bus.flush_i;
  assign bus.hi_o    = hi_q;
  assign bus.lo_o    = lo_q;
  assign state_o     = state_q;

endmodule
